// File: rtl/horner_poly_seq.sv
// horner_poly_seq: evaluates y = c0 + x*(c1 + x*(c2 + ... x*c_DEG)) by
// Horner's rule using one external pipelined multiplier (MUL_LAT stages).
// All operands are unsigned Q0.N fractions; each step keeps the high N bits
// of the product, adds the next coefficient and saturates to all-ones.
// Optional build macro HORNER_ROUND_EN: round the product half up (adds
// product bit N-1) instead of truncating. Latency and ports are unchanged.
// All sequential logic runs on the falling edge of clkn_i.
module horner_poly_seq #(
    parameter int N       = 6,
    parameter int DEG     = 3,
    parameter int MUL_LAT = 4
) (
    input  logic                   clkn_i,
    input  logic                   rstn_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [N-1:0]           x_i,
    input  logic [(DEG+1)*N-1:0]   coef_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [N-1:0]           y_o,
    output logic                   sat_o,
    output logic [N-1:0]           mul_a_o,
    output logic [N-1:0]           mul_b_o,
    input  logic [2*N-1:0]         mul_p_i
);

    localparam int KW = (DEG > 1) ? $clog2(DEG + 1) : 1;
    localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step sum in N+1 bits: high half of the product plus the coefficient.
    function automatic logic [N:0] step_sum(input logic [2*N-1:0] p,
                                            input logic [N-1:0]   c);
`ifdef HORNER_ROUND_EN
        step_sum = {1'b0, p[2*N-1:N]} + {{N{1'b0}}, p[N-1]} + {1'b0, c};
`else
        step_sum = {1'b0, p[2*N-1:N]} + {1'b0, c};
`endif
    endfunction

    state_t                 state_q, state_d;
    logic [(DEG+1)*N-1:0]   coef_q, coef_d;
    logic [KW-1:0]          k_q, k_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   jsat_q, jsat_d;
    logic                   out_valid_q, out_valid_d;
    logic [N-1:0]           y_q, y_d;
    logic                   sat_out_q, sat_out_d;
    logic [N-1:0]           mul_a_q, mul_a_d;
    logic [N-1:0]           mul_b_q, mul_b_d;

    logic                   accept_s;
    logic [N-1:0]           c_k_s;
    logic [N:0]             sum_s;
    logic                   step_sat_s;
    logic [N-1:0]           step_res_s;

    // Select coefficient c_k for the current Horner step.
    always_comb begin
        c_k_s = {N{1'b0}};
        for (int i = 0; i < DEG; i++) begin
            if (k_q == KW'(i)) begin
                c_k_s = coef_q[i*N +: N];
            end else begin
                c_k_s = c_k_s;
            end
        end
    end

    // One Horner step: add coefficient to the scaled product, then saturate.
    always_comb begin
        sum_s      = step_sum(mul_p_i, c_k_s);
        step_sat_s = sum_s[N];
        if (sum_s[N]) begin
            step_res_s = {N{1'b1}};
        end else begin
            step_res_s = sum_s[N-1:0];
        end
    end

    // FSM output: ready only in IDLE and never while reset is held.
    always_comb begin
        in_ready_o = rstn_i && (state_q == IDLE);
        accept_s   = in_valid_i && in_ready_o;
    end

    // FSM next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if ((cnt_q == CW'(0)) && (k_q == KW'(0))) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: job latch, step sequencing and result capture.
    always_comb begin
        coef_d      = coef_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        jsat_d      = jsat_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        sat_out_d   = sat_out_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    coef_d  = coef_i;
                    mul_a_d = coef_i[DEG*N +: N];
                    mul_b_d = x_i;
                    k_d     = KW'(DEG - 1);
                    cnt_d   = CW'(MUL_LAT);
                    jsat_d  = 1'b0;
                end else begin
                    coef_d  = coef_q;
                end
            end
            WAIT: begin
                if (cnt_q != CW'(0)) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (k_q == KW'(0)) begin
                    y_d         = step_res_s;
                    sat_out_d   = jsat_q | step_sat_s;
                    out_valid_d = 1'b1;
                end else begin
                    mul_a_d = step_res_s;
                    k_d     = k_q - KW'(1);
                    cnt_d   = CW'(MUL_LAT);
                    jsat_d  = jsat_q | step_sat_s;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, falling edge, async active-low reset.
    always_ff @(negedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            coef_q      <= {((DEG+1)*N){1'b0}};
            k_q         <= {KW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            jsat_q      <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= {N{1'b0}};
            sat_out_q   <= 1'b0;
            mul_a_q     <= {N{1'b0}};
            mul_b_q     <= {N{1'b0}};
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            jsat_q      <= jsat_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            sat_out_q   <= sat_out_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign y_o         = y_q;
    assign sat_o       = sat_out_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;

endmodule

// File: tb/tb_horner_poly_seq.sv
// Bench for horner_poly_seq: directed jobs, expected results pushed to a
// scoreboard queue at issue time and popped by a monitor on each result
// handshake. The external multiplier is a behavioural 4-edge pipeline.
module tb_horner_poly_seq;

    logic        clkn_i;
    logic        rstn_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [5:0]  x_i;
    logic [23:0] coef_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [5:0]  y_o;
    logic        sat_o;
    logic [5:0]  mul_a_o;
    logic [5:0]  mul_b_o;
    logic [11:0] mul_p_i;

    logic [11:0] pipe0, pipe1, pipe2;
    logic [6:0]  exp_q[$];
    logic [6:0]  mon_e;
    int          checks = 0;
    int          errors = 0;

    horner_poly_seq #(.N(6), .DEG(3), .MUL_LAT(4)) dut (
        .clkn_i(clkn_i), .rstn_i(rstn_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .x_i(x_i), .coef_i(coef_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .y_o(y_o), .sat_o(sat_o),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_p_i(mul_p_i)
    );

    initial clkn_i = 1'b1;
    always #5 clkn_i = ~clkn_i;

    // Multiplier model: operands captured on edge 1, product visible after edge 4.
    always @(negedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pipe0 <= 12'd0; pipe1 <= 12'd0; pipe2 <= 12'd0; mul_p_i <= 12'd0;
        end else begin
            pipe0   <= {6'd0, mul_a_o} * {6'd0, mul_b_o};
            pipe1   <= pipe0;
            pipe2   <= pipe1;
            mul_p_i <= pipe2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every result handshake is compared against the scoreboard head.
    always @(posedge clkn_i) begin
        if (rstn_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("y", {26'd0, y_o}, {26'd0, mon_e[6:1]});
                chk("sat", {31'd0, sat_o}, {31'd0, mon_e[0]});
            end
        end
    end

    task automatic issue(input logic [5:0] x, input logic [23:0] coef,
                         input logic [5:0] ey, input logic es, output int waited);
        in_valid_i = 1'b1; x_i = x; coef_i = coef;
        waited = 0;
        while (!in_ready_o && waited < 100) begin
            @(negedge clkn_i); #1; waited++;
        end
        chk("accept_timeout", {31'd0, waited < 100}, 32'd1);
        exp_q.push_back({ey, es});
        @(negedge clkn_i); #1;
    endtask

    task automatic do_job(input logic [5:0] x, input logic [23:0] coef,
                          input logic [5:0] ey, input logic es);
        int w;
        int n;
        issue(x, coef, ey, es, w);
        in_valid_i = 1'b0; x_i = ~x; coef_i = ~coef;
        chk("mul_b_is_x", {26'd0, mul_b_o}, {26'd0, x});
        chk("mul_a_is_cdeg", {26'd0, mul_a_o}, {26'd0, coef[23:18]});
        chk("busy_not_ready", {31'd0, in_ready_o}, 32'd0);
        n = 0;
        while (!out_valid_o && n < 100) begin
            @(negedge clkn_i); #1; n++;
        end
        chk("latency", n, 32'd15);
        if (out_ready_i) begin
            @(negedge clkn_i); #1;
        end
    endtask

    initial begin
        int w;
        int seen;
        logic [5:0] ey45;
`ifdef HORNER_ROUND_EN
        ey45 = 6'd16;
`else
        ey45 = 6'd14;
`endif
        rstn_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
        x_i = 6'd5; coef_i = 24'hABCDEF;
        repeat (3) @(negedge clkn_i);
        #1;
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_y", {26'd0, y_o}, 32'd0);
        chk("rst_sat", {31'd0, sat_o}, 32'd0);
        chk("rst_mul_a", {26'd0, mul_a_o}, 32'd0);
        chk("rst_mul_b", {26'd0, mul_b_o}, 32'd0);
        in_valid_i = 1'b0;
        rstn_i = 1'b1;
        @(negedge clkn_i); #1;
        chk("idle_ready", {31'd0, in_ready_o}, 32'd1);

        // Main function, directed vectors.
        do_job(6'd32, {6'd32, 6'd32, 6'd32, 6'd32}, 6'd60, 1'b0);
        do_job(6'd63, {6'd63, 6'd63, 6'd63, 6'd63}, 6'd63, 1'b1);
        do_job(6'd45, {6'd45, 6'd0, 6'd0, 6'd0}, ey45, 1'b0);
        do_job(6'd16, {6'd0, 6'd0, 6'd40, 6'd10}, 6'd20, 1'b0);

        // Backpressure: result held, busy, in_valid pulses ignored.
        out_ready_i = 1'b0;
        do_job(6'd32, {6'd32, 6'd32, 6'd32, 6'd32}, 6'd60, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid_i = i[0]; x_i = 6'(i * 7); coef_i = 24'(i * 12345);
            chk("bp_y_stable", {26'd0, y_o}, 32'd60);
            chk("bp_valid_held", {31'd0, out_valid_o}, 32'd1);
            chk("bp_not_ready", {31'd0, in_ready_o}, 32'd0);
            @(negedge clkn_i); #1;
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clkn_i); #1;
        chk("release_valid_low", {31'd0, out_valid_o}, 32'd0);
        chk("release_ready", {31'd0, in_ready_o}, 32'd1);

        // Reset mid-job: job abandoned, nothing comes out.
        issue(6'd32, {6'd32, 6'd32, 6'd32, 6'd32}, 6'd60, 1'b0, w);
        in_valid_i = 1'b0;
        repeat (6) @(negedge clkn_i);
        #2;
        rstn_i = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("midrst_mul_a", {26'd0, mul_a_o}, 32'd0);
        chk("midrst_mul_b", {26'd0, mul_b_o}, 32'd0);
        chk("midrst_y", {26'd0, y_o}, 32'd0);
        repeat (2) @(negedge clkn_i);
        #1;
        rstn_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clkn_i); #1;
            if (out_valid_o) seen = 1;
        end
        chk("no_output_after_reset", seen, 32'd0);
        do_job(6'd0, {6'd9, 6'd50, 6'd3, 6'd17}, 6'd17, 1'b0);

        // Back-to-back with in_valid held high: one accept per 17 edges.
        issue(6'd32, {6'd32, 6'd32, 6'd32, 6'd32}, 6'd60, 1'b0, w);
        issue(6'd16, {6'd0, 6'd0, 6'd40, 6'd10}, 6'd20, 1'b0, w);
        chk("b2b_gap_1", w, 32'd16);
        issue(6'd63, {6'd63, 6'd63, 6'd63, 6'd63}, 6'd63, 1'b1, w);
        chk("b2b_gap_2", w, 32'd16);
        in_valid_i = 1'b0;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clkn_i); #1; w++;
        end
        repeat (3) @(negedge clkn_i);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
